// File: rtl/ins_sequencer_if.sv
// ============================================================================
//  Module      : ins_sequencer_if
//  Description : Bus between the control unit (master) and the instruction
//                sequencer (slave): fetch handshake, commands and status.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ins_sequencer_if #(
    parameter int INSTRUCTION_LEN = 6,
    parameter int DATA_LEN        = 16,
    parameter int DEPTH           = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_LEN-1:0]        DR_out;
    logic                       dr_valid;
    logic                       dr_ready;
    logic                       LDIR;
    logic                       adv;
    logic                       jump;
    logic [INSTRUCTION_LEN-1:0] jump_addr;
    logic                       end_ins;
    logic [INSTRUCTION_LEN-1:0] data_out;
    logic [DATA_LEN-1:0]        ir_out;
    logic                       ir_valid;
    logic [CNT_W-1:0]           q_count;
    logic                       stall;

    modport master (
        output DR_out, dr_valid, LDIR, adv, jump, jump_addr, end_ins,
        input  dr_ready, data_out, ir_out, ir_valid, q_count, stall
    );

    modport slave (
        input  DR_out, dr_valid, LDIR, adv, jump, jump_addr, end_ins,
        output dr_ready, data_out, ir_out, ir_valid, q_count, stall
    );
endinterface

`default_nettype wire

// File: rtl/ins_sequencer.sv
// ============================================================================
//  Module      : ins_sequencer
//  Description : Instruction register with prefetch queue and micro-address
//                sequencer. Define INS_SEQ_BYPASS_EN to let LDIR on an empty
//                queue take DR_out directly when dr_valid is high.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ins_sequencer #(
    parameter int INSTRUCTION_LEN = 6,
    parameter int DATA_LEN        = 16,
    parameter int DEPTH           = 2,
    parameter int FETCH_ADDR      = 0
) (
    input  wire              clk,
    input  wire              rst,
    ins_sequencer_if.slave   bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]           c_PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]           c_DEPTH    = CNT_W'(DEPTH);
    localparam logic [INSTRUCTION_LEN-1:0] c_FETCH    = INSTRUCTION_LEN'(FETCH_ADDR);

    logic [DATA_LEN-1:0]        mem_q [DEPTH];
    logic [DATA_LEN-1:0]        mem_d [DEPTH];
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [INSTRUCTION_LEN-1:0] uaddr_q, uaddr_d;
    logic [DATA_LEN-1:0]        ir_q, ir_d;
    logic                       ir_valid_q, ir_valid_d;

    logic                       w_ready;
    logic                       w_avail;
    logic                       w_bypass;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_stall;
    logic [DATA_LEN-1:0]        w_word;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake qualifiers come from registered occupancy only, so a pop
    // never frees a slot for a push in the same cycle.
    always_comb begin
        w_ready  = (count_q < c_DEPTH);
        w_avail  = (count_q != '0);
`ifdef INS_SEQ_BYPASS_EN
        w_bypass = bus.LDIR && !w_avail && bus.dr_valid;
`else
        w_bypass = 1'b0;
`endif
        w_push   = bus.dr_valid && w_ready && !w_bypass;
        w_pop    = bus.LDIR && w_avail;
        w_stall  = bus.LDIR && !w_avail && !w_bypass;
        w_word   = w_pop ? mem_q[rd_ptr_q] : bus.DR_out;
    end

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        uaddr_d    = uaddr_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;

        if (w_push) begin
            mem_d[wr_ptr_q] = bus.DR_out;
            wr_ptr_d        = ptr_next(wr_ptr_q);
        end
        if (w_pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A stalled LDIR still owns the cycle: lower-priority commands drop.
        if (w_pop || w_bypass) begin
            ir_d       = w_word;
            ir_valid_d = 1'b1;
            uaddr_d    = w_word[INSTRUCTION_LEN-1:0];
        end else if (w_stall) begin
            uaddr_d = uaddr_q;
        end else if (bus.end_ins) begin
            uaddr_d = c_FETCH;
        end else if (bus.jump) begin
            uaddr_d = bus.jump_addr;
        end else if (bus.adv) begin
            uaddr_d = uaddr_q + INSTRUCTION_LEN'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            uaddr_q    <= c_FETCH;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            uaddr_q    <= uaddr_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    assign bus.dr_ready = w_ready;
    assign bus.stall    = w_stall;
    assign bus.q_count  = count_q;
    assign bus.data_out = uaddr_q;
    assign bus.ir_out   = ir_q;
    assign bus.ir_valid = ir_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_ins_sequencer.sv
// ============================================================================
//  Module      : tb_ins_sequencer
//  Description : Directed and random stimulus against a queue-based model of
//                the instruction sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ins_sequencer;
    localparam int IL    = 6;
    localparam int DL    = 16;
    localparam int DEPTH = 2;
    localparam int FETCH = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ins_sequencer_if #(.INSTRUCTION_LEN(IL), .DATA_LEN(DL), .DEPTH(DEPTH)) bus ();

    ins_sequencer #(
        .INSTRUCTION_LEN(IL),
        .DATA_LEN       (DL),
        .DEPTH          (DEPTH),
        .FETCH_ADDR     (FETCH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [DL-1:0] mq[$];
    logic [DL-1:0] m_ir;
    bit            m_valid;
    int            m_ua;

`ifdef INS_SEQ_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        bit exp_stall;
        exp_stall = bus.LDIR && (mq.size() == 0) && !(BYPASS && bus.dr_valid);
        check("q_count",  32'(bus.q_count),  32'(mq.size()));
        check("dr_ready", 32'(bus.dr_ready), 32'(mq.size() < DEPTH));
        check("stall",    32'(bus.stall),    32'(exp_stall));
        check("data_out", 32'(bus.data_out), 32'(m_ua));
        check("ir_out",   32'(bus.ir_out),   32'(m_ir));
        check("ir_valid", 32'(bus.ir_valid), 32'(m_valid));
    endtask

    task automatic model_reset();
        mq.delete();
        m_ir    = '0;
        m_valid = 1'b0;
        m_ua    = FETCH;
    endtask

    // Reference behaviour written directly from the command priority rules.
    task automatic model_update();
        bit            ready;
        bit            consumed;
        logic [DL-1:0] w;
        if (rst) begin
            model_reset();
            return;
        end
        ready    = mq.size() < DEPTH;
        consumed = 1'b0;
        if (bus.LDIR && mq.size() > 0) begin
            w       = mq.pop_front();
            m_ir    = w;
            m_valid = 1'b1;
            m_ua    = int'(w) % (1 << IL);
        end else if (bus.LDIR && BYPASS && bus.dr_valid) begin
            m_ir     = bus.DR_out;
            m_valid  = 1'b1;
            m_ua     = int'(bus.DR_out) % (1 << IL);
            consumed = 1'b1;
        end else if (bus.LDIR) begin
            m_ua = m_ua;
        end else if (bus.end_ins) begin
            m_ua = FETCH;
        end else if (bus.jump) begin
            m_ua = int'(bus.jump_addr);
        end else if (bus.adv) begin
            m_ua = (m_ua + 1) % (1 << IL);
        end
        if (bus.dr_valid && ready && !consumed) mq.push_back(bus.DR_out);
    endtask

    task automatic step(input bit r, input bit l, input bit a, input bit j,
                        input logic [IL-1:0] ja, input bit e, input bit dv,
                        input logic [DL-1:0] d);
        rst           = r;
        bus.LDIR      = l;
        bus.adv       = a;
        bus.jump      = j;
        bus.jump_addr = ja;
        bus.end_ins   = e;
        bus.dr_valid  = dv;
        bus.DR_out    = d;
        @(negedge clk);
        compare_all();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, '0, 0, 0, '0);
    endtask

    task automatic push(input logic [DL-1:0] d);
        step(0, 0, 0, 0, '0, 0, 1, d);
    endtask

    task automatic ldir();
        step(0, 1, 0, 0, '0, 0, 0, '0);
    endtask

    initial begin
        rst = 1'b1;
        bus.LDIR = 0; bus.adv = 0; bus.jump = 0; bus.jump_addr = '0;
        bus.end_ins = 0; bus.dr_valid = 0; bus.DR_out = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;

        // Reset state, then idle
        check("rst_data_out", 32'(bus.data_out), 32'(FETCH));
        check("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
        check("rst_dr_ready", 32'(bus.dr_ready), 32'd1);
        idle();
        idle();

        // Fill, overflow attempt, drain in order
        push(16'h1A25);
        push(16'h0007);
        check("full_count", 32'(bus.q_count), 32'd2);
        check("full_ready", 32'(bus.dr_ready), 32'd0);
        push(16'h3333);
        check("no_push_when_full", 32'(bus.q_count), 32'd2);
        ldir();
        check("ld1_data_out", 32'(bus.data_out), 32'h25);
        check("ld1_ir_out",   32'(bus.ir_out),   32'h1A25);
        ldir();
        check("ld2_data_out", 32'(bus.data_out), 32'h07);
        check("ld2_count",    32'(bus.q_count),  32'd0);

        // Micro-sequencing with wrap
        push(16'h003E);
        ldir();
        check("useq_start", 32'(bus.data_out), 32'h3E);
        step(0, 0, 1, 0, '0, 0, 0, '0);
        check("adv_3f", 32'(bus.data_out), 32'h3F);
        step(0, 0, 1, 0, '0, 0, 0, '0);
        check("adv_wrap", 32'(bus.data_out), 32'h00);
        step(0, 0, 0, 1, 6'h12, 0, 0, '0);
        check("jump_12", 32'(bus.data_out), 32'h12);
        step(0, 0, 0, 0, '0, 1, 0, '0);
        check("end_ins", 32'(bus.data_out), 32'(FETCH));
        check("end_keeps_ir", 32'(bus.ir_valid), 32'd1);

        // Priority
        push(16'h0009);
        step(0, 1, 1, 1, 6'h2A, 1, 0, '0);
        check("prio_ldir", 32'(bus.data_out), 32'h09);
        step(0, 0, 1, 1, 6'h2A, 1, 0, '0);
        check("prio_end_over_jump", 32'(bus.data_out), 32'(FETCH));

        // LDIR on empty queue with a word arriving
        check("pre_stall_count", 32'(bus.q_count), 32'd0);
        bus.LDIR = 1; bus.dr_valid = 1; bus.DR_out = 16'h0011;
        #1;
        check("empty_ldir_stall", 32'(bus.stall), BYPASS ? 32'd0 : 32'd1);
        step(0, 1, 0, 0, '0, 0, 1, 16'h0011);
        check("empty_ldir_data_out", 32'(bus.data_out), BYPASS ? 32'h11 : 32'(FETCH));
        check("empty_ldir_count",    32'(bus.q_count),  BYPASS ? 32'd0 : 32'd1);

        // Reset mid-operation with full queue and LDIR
        while (mq.size() < DEPTH) push(16'h0A00 + 16'(mq.size()));
        check("pre_rst_count", 32'(bus.q_count), 32'd2);
        step(1, 1, 0, 0, '0, 0, 1, 16'h0F0F);
        check("rst_mid_count",    32'(bus.q_count),  32'd0);
        check("rst_mid_ir_valid", 32'(bus.ir_valid), 32'd0);
        check("rst_mid_data_out", 32'(bus.data_out), 32'(FETCH));

        // Randomised traffic
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 1),
                 ($urandom_range(0, 4) == 0),
                 IL'($urandom),
                 ($urandom_range(0, 7) == 0),
                 $urandom_range(0, 1),
                 DL'($urandom));
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
